// File: rtl/demux_lane_collector_pkg.sv
// Shared lane definitions and the round-robin lane picker for the demux lane collector.
package demux_lane_collector_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic  found;
    lane_t lane;
  } rr_pick_t;

  // First requesting lane after ptr, wrapping modulo NUM_LANES; ptr itself is checked last.
  function automatic rr_pick_t rr_pick(input lane_t ptr, input logic [NUM_LANES-1:0] req);
    rr_pick_t r;
    lane_t    cand;
    r.found = 1'b0;
    r.lane  = ptr;
    // Walk from the farthest candidate to the nearest so the nearest requester is kept.
    for (int k = NUM_LANES; k >= 1; k--) begin
      cand = ptr + lane_t'(k);
      if (req[cand]) begin
        r.found = 1'b1;
        r.lane  = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_lane_collector_lane_shift_assembler.sv
// One lane: serial-to-parallel shift register, bit counter and a single-word hold slot.
module lane_shift_assembler
  import demux_lane_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic             din,
  input  logic             drain,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_p1;
  logic             accept;

  // A completed word is only taken if the slot is free or being emptied this cycle.
  assign accept = done_p1 && (!hold_full || drain);
  assign done   = done_p1;

  // Stage p0 -> p1: shift in lane bits, count them, flag the edge that completed a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      cnt     <= '0;
      done_p1 <= 1'b0;
    end else begin
      if (strobe) begin
        shreg <= {shreg[WIDTH-2:0], din};
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      done_p1 <= strobe && (cnt == LAST);
    end
  end

  // Stage p1 -> hold: move the finished word into the hold slot, or leave the old word on a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= shreg;
      hold_full <= 1'b1;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_lane_collector.sv
// Collects serial bits from four demux lanes into words and merges them onto one valid/ready port.
module demux_lane_collector
  import demux_lane_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic [LANE_W-1:0]    sel,
  input  logic                 din_0,
  input  logic                 din_1,
  input  logic                 din_2,
  input  logic                 din_3,
  output logic [WIDTH-1:0]     word_data,
  output logic [LANE_W-1:0]    word_chan,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [NUM_LANES-1:0] overflow,
  input  logic                 ovf_clr
);

  logic [NUM_LANES-1:0] din_vec;
  logic [NUM_LANES-1:0] hold_full;
  logic [NUM_LANES-1:0] done;
  logic [NUM_LANES-1:0] drain;
  logic [NUM_LANES-1:0] drop;
  logic [WIDTH-1:0]     hold [NUM_LANES];
  lane_t                ptr;
  logic                 load;
  rr_pick_t             pick;

  assign din_vec = {din_3, din_2, din_1, din_0};
  assign load    = !word_valid || word_ready;
  assign pick    = rr_pick(ptr, hold_full);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign drain[g] = load && pick.found && (pick.lane == lane_t'(g));
    assign drop[g]  = done[g] && hold_full[g] && !drain[g];

    lane_shift_assembler #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .strobe    (bit_valid && (sel == lane_t'(g))),
      .din       (din_vec[g]),
      .drain     (drain[g]),
      .hold      (hold[g]),
      .hold_full (hold_full[g]),
      .done      (done[g])
    );
  end

  // Output register: load the next full lane in round-robin order whenever the slot is free or consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_chan  <= '0;
      word_valid <= 1'b0;
      ptr        <= lane_t'(NUM_LANES - 1);
    end else if (load) begin
      if (pick.found) begin
        word_data  <= hold[pick.lane];
        word_chan  <= pick.lane;
        word_valid <= 1'b1;
        ptr        <= pick.lane;
      end else begin
        word_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow flags; a new drop in the same cycle as a clear keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= '0;
    end else begin
      overflow <= (ovf_clr ? '0 : overflow) | drop;
    end
  end

endmodule

// File: tb/tb_demux_lane_collector.sv
// Directed bench for demux_lane_collector with a word-level reference model and per-cycle compare.
module tb_demux_lane_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         bit_valid;
  logic [1:0]   sel;
  logic         din_0, din_1, din_2, din_3;
  logic [W-1:0] word_data;
  logic [1:0]   word_chan;
  logic         word_valid;
  logic         word_ready;
  logic [3:0]   overflow;
  logic         ovf_clr;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  demux_lane_collector #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .sel        (sel),
    .din_0      (din_0),
    .din_1      (din_1),
    .din_2      (din_2),
    .din_3      (din_3),
    .word_data  (word_data),
    .word_chan  (word_chan),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bit lists per lane, one pending finished word, one hold slot, output slot.
  int mb [4][$];
  int m_pend [4];
  bit m_pend_v [4];
  bit m_full [4];
  int m_hold [4];
  bit m_valid;
  int m_data, m_chan, m_ptr;
  bit [3:0] m_ovf;

  always @(posedge clk) begin : model
    int pick, b, v, s;
    bit ld;
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        mb[l].delete();
        m_pend_v[l] = 0; m_full[l] = 0; m_hold[l] = 0; m_pend[l] = 0;
      end
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 3; m_ovf = 0;
    end else begin
      ld = !m_valid || word_ready;
      pick = -1;
      if (ld) begin
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && m_full[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        if (pick >= 0) begin
          m_valid = 1; m_data = m_hold[pick]; m_chan = pick; m_ptr = pick; m_full[pick] = 0;
        end else begin
          m_valid = 0;
        end
      end
      if (ovf_clr) m_ovf = 0;
      for (int l = 0; l < 4; l++) begin
        if (m_pend_v[l]) begin
          if (!m_full[l]) begin
            m_hold[l] = m_pend[l]; m_full[l] = 1;
          end else begin
            m_ovf[l] = 1'b1;
          end
          m_pend_v[l] = 0;
        end
      end
      if (bit_valid) begin
        s = int'(sel);
        case (s)
          0: b = int'(din_0);
          1: b = int'(din_1);
          2: b = int'(din_2);
          default: b = int'(din_3);
        endcase
        mb[s].push_back(b);
        if (mb[s].size() == W) begin
          v = 0;
          for (int i = 0; i < W; i++) v = v * 2 + mb[s][i];
          m_pend[s] = v; m_pend_v[s] = 1;
          mb[s].delete();
        end
      end
    end
  end

  // Accepted words, encoded as chan*256 + data.
  int log_q [$];
  always @(posedge clk) begin
    if (!rst && word_valid === 1'b1 && word_ready === 1'b1)
      log_q.push_back(int'(word_chan) * 256 + int'(word_data));
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", 32'(word_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_data", 32'(word_data), 32'(m_data));
        chk("model_chan", 32'(word_chan), 32'(m_chan));
      end
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic drive_bit(input int l, input bit b);
    bit_valid = 1'b1;
    sel   = 2'(l);
    din_0 = (l == 0) && b;
    din_1 = (l == 1) && b;
    din_2 = (l == 2) && b;
    din_3 = (l == 3) && b;
    @(negedge clk);
    bit_valid = 1'b0;
    din_0 = 0; din_1 = 0; din_2 = 0; din_3 = 0;
  endtask

  task automatic send_bits(input int l, input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) drive_bit(l, w[W-1-i]);
  endtask

  task automatic send_word(input int l, input logic [W-1:0] w);
    send_bits(l, w, W);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] wa, wb;

  initial begin
    rst = 1'b1; bit_valid = 0; sel = 0; din_0 = 0; din_1 = 0; din_2 = 0; din_3 = 0;
    word_ready = 0; ovf_clr = 0;
    idle(2);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_data", 32'(word_data), 0);
    chk("rst_chan", 32'(word_chan), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(1);

    // Single lane word with exact latency and one-cycle valid.
    word_ready = 1'b1;
    send_word(2, 8'hB2);
    idle(1);
    chk("t1_lat_n1", 32'(word_valid), 0);
    idle(1);
    chk("t1_valid", 32'(word_valid), 1);
    chk("t1_data", 32'(word_data), 32'hB2);
    chk("t1_chan", 32'(word_chan), 2);
    idle(1);
    chk("t1_one_cycle", 32'(word_valid), 0);
    chk("t1_count", 32'(log_q.size()), 1);
    chk("t1_word", 32'(log_q[0]), 32'h2B2);

    // Interleaved lanes 0 and 1.
    log_q.delete();
    wa = 8'hA5; wb = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      drive_bit(0, wa[i]);
      drive_bit(1, wb[i]);
    end
    idle(6);
    chk("t2_count", 32'(log_q.size()), 2);
    chk("t2_first", 32'(log_q[0]), 32'h0A5);
    chk("t2_second", 32'(log_q[1]), 32'h13C);
    chk("t2_ovf", 32'(overflow), 0);

    // Backpressure with all four lanes full, then round-robin drain.
    log_q.delete();
    word_ready = 1'b0;
    send_word(0, 8'h11);
    send_word(1, 8'h22);
    send_word(2, 8'h33);
    send_word(3, 8'h44);
    idle(3);
    chk("t3_hold_valid", 32'(word_valid), 1);
    chk("t3_hold_chan", 32'(word_chan), 0);
    chk("t3_hold_data", 32'(word_data), 32'h11);
    word_ready = 1'b1;
    idle(1);
    chk("t3_rr1", {word_chan, word_data}, 32'h122);
    idle(1);
    chk("t3_rr2", {word_chan, word_data}, 32'h233);
    idle(1);
    chk("t3_rr3", {word_chan, word_data}, 32'h344);
    chk("t3_rr3_valid", 32'(word_valid), 1);
    idle(1);
    chk("t3_empty", 32'(word_valid), 0);
    chk("t3_count", 32'(log_q.size()), 4);

    // Overflow on lane 3, then clear.
    log_q.delete();
    word_ready = 1'b0;
    send_word(3, 8'h01);
    send_word(3, 8'h02);
    send_word(3, 8'h03);
    idle(3);
    chk("t4_ovf_set", 32'(overflow), 32'h8);
    word_ready = 1'b1;
    idle(4);
    chk("t4_count", 32'(log_q.size()), 2);
    chk("t4_first", 32'(log_q[0]), 32'h301);
    chk("t4_second", 32'(log_q[1]), 32'h302);
    chk("t4_ovf_sticky", 32'(overflow), 32'h8);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);

    // Drain of lane 1 coinciding with the next word on lane 1 (two alignments).
    for (int d = 0; d < 2; d++) begin
      log_q.delete();
      word_ready = 1'b0;
      send_word(1, 8'h5A);
      send_word(1, 8'h6B);
      wa = 8'h7C + 8'(d);
      send_bits(1, wa, W - 1);
      if (d == 0) begin
        word_ready = 1'b1;
        drive_bit(1, wa[0]);
      end else begin
        drive_bit(1, wa[0]);
        word_ready = 1'b1;
      end
      idle(5);
      chk("t5_count", 32'(log_q.size()), 3);
      chk("t5_a", 32'(log_q[0]), 32'h15A);
      chk("t5_b", 32'(log_q[1]), 32'h16B);
      chk("t5_c", 32'(log_q[2]), 32'h100 + 32'(wa));
      chk("t5_ovf", 32'(overflow), 0);
    end

    // Reset with a partial word and held/pending words in flight.
    word_ready = 1'b0;
    send_word(2, 8'h77);
    send_word(2, 8'h78);
    send_word(2, 8'h79);
    send_bits(0, 8'hB0, 5);
    chk("t6_pre_valid", 32'(word_valid), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_valid", 32'(word_valid), 0);
    chk("t6_data", 32'(word_data), 0);
    chk("t6_chan", 32'(word_chan), 0);
    chk("t6_ovf", 32'(overflow), 0);
    log_q.delete();
    word_ready = 1'b1;
    send_word(0, 8'hFF);
    idle(4);
    chk("t6_count", 32'(log_q.size()), 1);
    chk("t6_word", 32'(log_q[0]), 32'h0FF);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
